// File: rtl/ripple_count_ctrl.sv
// Sequencer for a 4-bit asynchronous ripple counter: clear, gated count window,
// settle, then sample {wrap-extension, synced count} and offer it over valid/ready.
module ripple_count_ctrl #(
  parameter int CNT_W  = 4,
  parameter int EXT_W  = 4,
  parameter int WIN_W  = 8,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       cnt_q,
  output logic                   cnt_en,
  output logic                   cnt_clr,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CNT_W+EXT_W-1:0] result,
  output logic                   ovf
);

  localparam int RES_W = CNT_W + EXT_W;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_T = TMR_W'(SETTLE);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_COUNT,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [EXT_W-1:0] ext_q, ext_d;
  logic             ovf_q, ovf_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] sync1_q, sync1_d;
  logic [CNT_W-1:0] sync2_q, sync2_d;
  logic             msb_prev_q, msb_prev_d;
  logic             cnt_en_q, cnt_en_d;
  logic             cnt_clr_q, cnt_clr_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             tracking;
  logic             wrap;

  // Synchronizer and wrap extension. The counter and the synchronizer are both
  // cleared during CLEAR, so a stale MSB from the previous run cannot look like a wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sync1_d    = cnt_q;
    sync2_d    = sync1_q;
    msb_prev_d = sync2_q[CNT_W-1];
    ext_d      = ext_q;
    ovf_d      = ovf_q;
    tracking   = (state_q == ST_COUNT) || (state_q == ST_SETTLE);
    wrap       = tracking && msb_prev_q && !sync2_q[CNT_W-1];

    if (state_q == ST_CLEAR) begin
      sync1_d    = '0;
      sync2_d    = '0;
      msb_prev_d = 1'b0;
      ext_d      = '0;
      ovf_d      = 1'b0;
    end else if (wrap && !ovf_q) begin
      if (&ext_q) begin
        ovf_d = 1'b1;
      end else begin
        ext_d = ext_q + EXT_W'(1);
      end
    end
  end

  // Sequencer. tmr_q holds the remaining window length in COUNT and the
  // remaining settle time in SETTLE.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          tmr_d   = TMR_W'(win_len);
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_T;
        end else begin
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_q == TMR_ONE) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_T;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_q == TMR_ONE) begin
          // Use the next-state extension so a wrap seen on this very edge is included.
          state_d  = ST_HOLD;
          result_d = ovf_d ? '1 : {ext_d, sync2_q};
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered and glitch-free.
    cnt_en_d    = (state_d == ST_COUNT);
    cnt_clr_d   = (state_d == ST_CLEAR);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every flop, synchronizer stages included, is reset so a mid-run reset leaves no stale state.
    if (!reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      ext_q       <= '0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      msb_prev_q  <= 1'b0;
      cnt_en_q    <= 1'b0;
      cnt_clr_q   <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ext_q       <= ext_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      msb_prev_q  <= msb_prev_d;
      cnt_en_q    <= cnt_en_d;
      cnt_clr_q   <= cnt_clr_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cnt_clr   = cnt_clr_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Bench for ripple_count_ctrl: a behavioural ripple counter fed by per-cycle event
// schedules, with expected counts computed as a plain saturating sum of events.
module tb_ripple_count_ctrl;

  localparam int CNT_W  = 4;
  localparam int EXT_W  = 4;
  localparam int WIN_W  = 8;
  localparam int SETTLE = 4;
  localparam int RES_W  = CNT_W + EXT_W;
  localparam int RES_MAX = (1 << RES_W) - 1;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             abort;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] result;
  logic             ovf;

  int n_checks = 0;
  int n_pass   = 0;

  int               sched[$];
  int               gate_idx   = 0;
  int               clr_cycles = 0;
  int               en_cycles  = 0;
  logic [CNT_W-1:0] rc         = '0;
  logic [RES_W-1:0] last_result = '0;

  ripple_count_ctrl #(
    .CNT_W (CNT_W),
    .EXT_W (EXT_W),
    .WIN_W (WIN_W),
    .SETTLE(SETTLE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .win_len  (win_len),
    .abort    (abort),
    .cnt_q    (cnt_q),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .result   (result),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cnt_q = rc;

  // Ripple counter model: events of a gated cycle land mid-cycle, away from clk.
  always @(posedge clk) begin
    #2;
    if (cnt_clr) begin
      rc = '0;
    end else if (cnt_en) begin
      int ev;
      ev = (gate_idx < sched.size()) ? sched[gate_idx] : 1;
      rc = rc + CNT_W'(ev);
      gate_idx++;
    end
  end

  always @(negedge clk) begin
    if (cnt_clr) clr_cycles++;
    if (cnt_en)  en_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // One measurement; hold > 0 keeps res_ready low that many cycles and pulses start meanwhile.
  task automatic run_meas(input int win, input int hold, input bit abort_with_start);
    int total;
    int k;
    logic [RES_W-1:0] exp_res;
    logic exp_ovf;
    total = 0;
    foreach (sched[i]) total += sched[i];
    exp_ovf = (total > RES_MAX);
    exp_res = exp_ovf ? RES_W'(RES_MAX) : RES_W'(total);
    gate_idx   = 0;
    clr_cycles = 0;
    en_cycles  = 0;

    @(negedge clk);
    start   = 1'b1;
    abort   = abort_with_start;
    win_len = WIN_W'(win);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("clear_after_start", {busy, cnt_clr, cnt_en}, 3'b110);

    k = 0;
    while (!res_valid && k < win + SETTLE + 20) begin
      @(negedge clk);
      k++;
    end
    check("valid_latency", k, win + SETTLE + 1);
    check("clr_cycles", clr_cycles, 1);
    check("gate_cycles", en_cycles, win);
    check("result", result, exp_res);
    check("ovf", ovf, exp_ovf);

    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      @(negedge clk);
      check("hold_valid", {res_valid, busy}, 2'b11);
      check("hold_result", {ovf, result}, {exp_ovf, exp_res});
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_after_ack", {res_valid, busy, cnt_clr, cnt_en}, 4'b0000);
    last_result = exp_res;
  endtask

  task automatic fill_rand(input int win, input int max_ev);
    sched.delete();
    for (int i = 0; i < win; i++) sched.push_back(int'($urandom_range(max_ev, 0)));
  endtask

  task automatic fill_const(input int win, input int ev);
    sched.delete();
    for (int i = 0; i < win; i++) sched.push_back(ev);
  endtask

  initial begin
    int seen;

    reset     = 1'b0;
    start     = 1'b1;
    abort     = 1'b0;
    res_ready = 1'b0;
    win_len   = WIN_W'(5);
    #12;
    check("reset_outputs", {cnt_en, cnt_clr, busy, res_valid, ovf, result}, '0);
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", {busy, cnt_clr, cnt_en, res_valid}, 4'b0000);

    // Basic: 7 events spread over a 10-cycle window.
    sched.delete();
    for (int i = 0; i < 10; i++) sched.push_back((i % 3 != 2) ? 1 : 0);
    run_meas(10, 0, 1'b0);

    // Wrap: 37 single events spaced 4 cycles apart inside a 200-cycle window.
    sched.delete();
    for (int i = 0; i < 200; i++) sched.push_back((i % 4 == 0 && i / 4 < 37) ? 1 : 0);
    run_meas(200, 0, 1'b0);

    // Overflow: 300 events in one 255-cycle window, then a saturated-rate window.
    sched.delete();
    for (int i = 0; i < 255; i++) sched.push_back((i < 45) ? 2 : 1);
    run_meas(255, 0, 1'b0);
    fill_const(255, 3);
    run_meas(255, 0, 1'b0);

    // Exactly full scale: 255 events is the largest count without overflow.
    fill_const(255, 1);
    run_meas(255, 0, 1'b0);

    // Zero-length window goes CLEAR -> SETTLE.
    sched.delete();
    run_meas(0, 0, 1'b0);

    // Backpressure with a start pulse inside HOLD, then abort alongside start in IDLE.
    fill_rand(12, 3);
    run_meas(12, 5, 1'b0);
    fill_rand(9, 3);
    run_meas(9, 0, 1'b1);

    // Abort on the third gated cycle of a 10-cycle window.
    fill_const(10, 1);
    gate_idx = 0;
    @(negedge clk);
    start   = 1'b1;
    win_len = WIN_W'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outputs", {cnt_en, busy, res_valid}, 3'b000);
    check("abort_result_kept", result, last_result);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid || busy) seen++;
    end
    check("abort_stays_idle", seen, 0);

    // Reset at the same point of the window.
    gate_idx = 0;
    @(negedge clk);
    start   = 1'b1;
    win_len = WIN_W'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrun_reset_outputs", {cnt_en, cnt_clr, busy, res_valid, ovf, result}, '0);
    @(negedge clk);
    reset = 1'b1;
    last_result = '0;

    fill_const(10, 1);
    run_meas(10, 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int w;
      w = int'($urandom_range(60, 1));
      fill_rand(w, 3);
      run_meas(w, int'($urandom_range(2, 0)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ripple_count_ctrl.md
Name: ripple_count_ctrl

Overview:
Sequencer for the 4-bit asynchronous ripple counter. It clears the counter, opens a gated count window of programmable length, and waits for ripple settling before sampling the count into the clk domain. It extends the count past counter wrap-around by tracking the MSB. The result is presented to a host over a valid/ready handshake, and the block sits between the host control logic and the ripple counter instance.

Parameters:
CNT_W, 4, ripple counter width (width of cnt_q)
EXT_W, 4, extension bits counting counter wraps; result width is CNT_W+EXT_W
WIN_W, 8, width of win_len
SETTLE, 4, cycles between gate close and final sample; legal range is >= 3 (2-flop sync plus ripple settle)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset; reset=0 asserts
start  in  1  request a measurement; sampled only in IDLE
win_len  in  WIN_W  gate length in clk cycles; latched on accepted start
abort  in  1  cancel an in-flight measurement
cnt_q  in  CNT_W  ripple counter output (asynchronous to clk)
cnt_en  out  1  count gate to the ripple counter
cnt_clr  out  1  clear to the ripple counter, 1-cycle pulse
busy  out  1  high in every state except IDLE
res_valid  out  1  result available
res_ready  in  1  host accepts result
result  out  CNT_W+EXT_W  event count {ext, cnt}
ovf  out  1  count exceeded 2^(CNT_W+EXT_W)-1; valid with res_valid

Behaviour:
- Reset (reset=0, async): state=IDLE. cnt_en, cnt_clr, busy, res_valid, ovf = 0. result=0. Sync flops and ext counter = 0.
- States: IDLE, CLEAR, COUNT, SETTLE, HOLD.
- IDLE:
  - start=1 at edge T -> CLEAR at T+1; latch win_len.
  - If win_len=0 -> still CLEAR, then SETTLE with no COUNT; result=0.
- CLEAR: cnt_clr=1 for exactly 1 cycle. Clear ext counter, ovf, sync flops. Next state COUNT.
- COUNT: cnt_en=1 for exactly win_len cycles (registered output, no glitches). Then SETTLE.
- SETTLE: cnt_en=0 for SETTLE cycles. On the last SETTLE cycle, capture result={ext, cnt_q_sync}. Next state HOLD.
- Sampling cnt_q: every bit passes through a 2-flop synchronizer. The multi-bit value is only used once frozen, i.e. at the end of SETTLE.
- Wrap tracking (COUNT and SETTLE): a synced MSB 1->0 transition increments ext.
  - If ext is all ones when another wrap occurs, set ovf=1 and freeze ext.
  - If ovf=1, result is forced to all ones.
- Input constraint: the MSB high and low phases of cnt_q each last >= 2 clk cycles; event rate is bounded accordingly.
- HOLD:
  - res_valid=1; result and ovf stay stable until res_valid&&res_ready.
  - The handshake cycle returns to IDLE next edge, where res_valid=0.
  - start is ignored in HOLD.
- abort=1 in CLEAR, COUNT or SETTLE -> IDLE next edge. cnt_en=0 from that edge; no res_valid; result keeps its previous value.
- abort in IDLE or HOLD has no effect.
- abort and start in the same IDLE cycle: start wins; abort in IDLE is ignored.
- Reset mid-operation: immediate return to reset values; the next start runs a full CLEAR.
- Latency for an accepted start at edge T:
  - cnt_clr high during T+1.
  - cnt_en high during T+2 .. T+1+win_len.
  - res_valid rises at T+2+win_len+SETTLE.

Test Plan:
- Reset: hold reset=0 for 12 ns with start=1 -> all outputs 0, busy=0; after release, stays IDLE until start is sampled.
- Basic: win_len=10, bench ripple model fed 7 events inside the window -> exactly 1 cnt_clr cycle; cnt_en high exactly 10 cycles; res_valid 4 cycles after gate close; result=7, ovf=0.
- Wrap: win_len=200, 37 events spaced 4 clk -> result=37 (0x25), ovf=0; ext=2.
- Overflow: win_len=255 at max legal rate, 300 events total across back-to-back runs adjusted to exceed 255 in one run -> ovf=1, result=0xFF.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid and pulse start -> result stable, start ignored; res_ready=1 -> IDLE next cycle, then new start accepted.
- Abort/reset mid-COUNT: abort at cycle 3 of a 10-cycle window -> cnt_en=0 next edge, no res_valid, busy=0. Repeat with reset=0 at the same point -> immediate zero outputs. A following run returns the correct count.
